// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads one word per pc value, hands it to decode over
// valid/ready and steers the pc. Define FETCH_PERF_EN to add fetch/stall counters.
module fetch_unit #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_inc,
  output logic              pc_write_en,
  output logic [ADDR_W-1:0] pc_write_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_VALID,
    S_FLUSH
  } state_t;

  state_t            state_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              instr_valid_q;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic              handshake_d;

  // Redirect outranks the handshake so the pc never sees both controls at once.
  assign handshake_d   = !rst && (state_q == S_VALID) && instr_ready && !redirect;
  assign pc_inc        = handshake_d;
  assign pc_write_en   = redirect && !rst;
  assign pc_write_data = redirect_addr;

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_ISSUE;
        S_ISSUE: begin
          // A redirect here reloads the pc first; the request goes out next cycle.
          if (!redirect) begin
            mem_addr_q <= pc_in;
            mem_req_q  <= 1'b1;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            if (redirect) begin
              state_q <= S_ISSUE;
            end else begin
              instr_q       <= mem_rdata;
              instr_pc_q    <= mem_addr_q;
              instr_valid_q <= 1'b1;
              state_q       <= S_VALID;
            end
          end else if (redirect) begin
            state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          // The stale request must still complete before a new one is issued.
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= S_ISSUE;
          end
        end
        S_VALID: begin
          if (redirect || instr_ready) begin
            instr_valid_q <= 1'b0;
            state_q       <= S_ISSUE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;
  logic        stall_d;

  assign stall_d   = ((state_q == S_WAIT) || (state_q == S_FLUSH)) && !mem_ack;
  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (handshake_d) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall_d)     stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: pc and memory models around the DUT, directed scenarios
// followed by randomized redirect/ready/latency traffic checked by a scoreboard.
module tb_fetch_unit;
  localparam int AW = 20;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] pc_q = '0;
  logic          pc_inc, pc_write_en;
  logic [AW-1:0] pc_write_data;
  logic          mem_req, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          instr_valid;
  logic          instr_ready = 1'b1;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
`ifdef FETCH_PERF_EN
  logic [31:0]   fetch_cnt, stall_cnt;
  logic [31:0]   m_fetch = '0, m_stall = '0;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_q),
    .pc_inc(pc_inc), .pc_write_en(pc_write_en), .pc_write_data(pc_write_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_addr(redirect_addr)
`ifdef FETCH_PERF_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
  );

  // Program counter block.
  always @(posedge clk) begin
    if (rst) pc_q <= '0;
    else if (pc_write_en) pc_q <= pc_write_data;
    else if (pc_inc) pc_q <= pc_q + 20'd1;
  end

  // Memory: word at address a is {12'hA5A, a}; lat_cfg < 0 picks a random latency.
  int lat_cfg = 0;
  int wait_cnt = 0;
  assign mem_ack   = mem_req && (wait_cnt == 0);
  assign mem_rdata = {12'hA5A, mem_addr};
  always @(posedge clk) begin
    if (rst || !mem_req || mem_ack) wait_cnt <= (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
    else wait_cnt <= wait_cnt - 1;
  end

  int n_checks = 0;
  int n_pass = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Scoreboard and protocol monitor, sampled on the falling edge.
  logic          rst_at_edge = 1'b0;
  always @(posedge clk) rst_at_edge <= rst;

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] e, e_next, prev_addr, prev_ipc, last_hs_pc;
  logic [DW-1:0] prev_instr;
  logic          prev_wait = 1'b0, prev_hold = 1'b0, hs;
  int            hs_count = 0, cycle = 0, last_hs_cycle = -1;
  bit            spacing_on = 1'b0;

  always @(negedge clk) begin
    cycle++;
    hs = instr_valid && instr_ready && !redirect && !rst;
    chk("pc_write_en", 64'(pc_write_en), 64'(redirect && !rst));
    chk("pc_write_data", 64'(pc_write_data), 64'(redirect_addr));
    chk("pc_inc", 64'(pc_inc), 64'(hs));
    if (rst_at_edge) begin
      chk("rst_mem_req", 64'(mem_req), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_instr_valid", 64'(instr_valid), 64'd0);
      chk("rst_instr", 64'(instr), 64'd0);
      chk("rst_instr_pc", 64'(instr_pc), 64'd0);
    end else begin
      if (prev_wait) begin
        chk("mem_req_held", 64'(mem_req), 64'd1);
        chk("mem_addr_stable", 64'(mem_addr), 64'(prev_addr));
      end
      if (prev_hold) begin
        chk("hold_valid", 64'(instr_valid), 64'd1);
        chk("hold_instr", 64'(instr), 64'(prev_instr));
        chk("hold_instr_pc", 64'(instr_pc), 64'(prev_ipc));
      end
    end
`ifdef FETCH_PERF_EN
    chk("fetch_cnt", 64'(fetch_cnt), 64'(m_fetch));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    if (rst) begin
      m_fetch = '0;
      m_stall = '0;
    end else begin
      if (hs) m_fetch = m_fetch + 32'd1;
      if (mem_req && !mem_ack) m_stall = m_stall + 32'd1;
    end
`endif
    if (hs) begin
      if (exp_q.size() == 0) begin
        chk("sb_nonempty", 64'd0, 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("instr_pc", 64'(instr_pc), 64'(e));
        chk("instr", 64'(instr), 64'({12'hA5A, e}));
        e_next = e + 20'd1;
        exp_q.push_back(e_next);
      end
      if (spacing_on && last_hs_cycle >= 0) chk("hs_spacing", 64'(cycle - last_hs_cycle), 64'd3);
      last_hs_cycle = cycle;
      last_hs_pc = instr_pc;
      hs_count++;
    end
    if (!spacing_on) last_hs_cycle = -1;
    if (rst) begin
      exp_q.delete();
      exp_q.push_back('0);
    end else if (redirect) begin
      exp_q.delete();
      exp_q.push_back(redirect_addr);
    end
    prev_wait  = mem_req && !mem_ack && !rst;
    prev_addr  = mem_addr;
    prev_hold  = instr_valid && !instr_ready && !redirect && !rst;
    prev_instr = instr;
    prev_ipc   = instr_pc;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic level);
    int n = 0;
    while (mem_req !== level && n < 50) begin cyc(1); n++; end
    if (n >= 50) chk("timeout_mem_req", 64'(mem_req), 64'(level));
  endtask

  task automatic wait_valid();
    int n = 0;
    while (instr_valid !== 1'b1 && n < 50) begin cyc(1); n++; end
    if (n >= 50) chk("timeout_instr_valid", 64'(instr_valid), 64'd1);
  endtask

  task automatic wait_hs(input int target);
    int n = 0;
    while (hs_count < target && n < 100) begin cyc(1); n++; end
    if (n >= 100) chk("timeout_handshake", 64'(hs_count), 64'(target));
  endtask

  int            n, h0;
  logic [AW-1:0] saved_pc;

  initial begin
    rst = 1'b1; instr_ready = 1'b1; redirect = 1'b0; lat_cfg = 0;
    cyc(3);
    // Zero-wait memory, decode always ready: one instruction every 3 cycles.
    spacing_on = 1'b1;
    rst = 1'b0;
    wait_hs(4);
    spacing_on = 1'b0;

    // Four-cycle request: ack on the fourth cycle of mem_req.
    lat_cfg = 3;
    wait_req(1'b0); wait_req(1'b1);
    n = 0;
    while (mem_req && n < 20) begin n++; cyc(1); end
    chk("req_cycles", 64'(n), 64'd4);
    chk("valid_at_ack", 64'(instr_valid), 64'd1);

    // Decode stalls for 5 cycles with an instruction presented.
    lat_cfg = 0;
    instr_ready = 1'b0;
    wait_valid();
    saved_pc = pc_q;
    cyc(5);
    chk("pc_hold", 64'(pc_q), 64'(saved_pc));
    instr_ready = 1'b1;
    cyc(1);
    chk("pc_after_ready", 64'(pc_q), 64'(saved_pc + 20'd1));

    // Redirect while waiting: request flushed, next fetch from the target.
    lat_cfg = 2;
    wait_req(1'b0); wait_req(1'b1);
    redirect = 1'b1; redirect_addr = 20'h3BEEF;
    cyc(1);
    redirect = 1'b0;
    wait_req(1'b0); wait_req(1'b1);
    chk("flush_next_addr", 64'(mem_addr), 64'h3BEEF);
    h0 = hs_count;
    wait_hs(h0 + 1);
    chk("flush_next_pc", 64'(last_hs_pc), 64'h3BEEF);

    // Redirect coinciding with a would-be handshake.
    lat_cfg = 0;
    wait_valid();
    redirect = 1'b1; redirect_addr = 20'h00100;
    cyc(1);
    redirect = 1'b0;
    h0 = hs_count;
    wait_hs(h0 + 1);
    chk("redir_vs_hs_pc", 64'(last_hs_pc), 64'h00100);

    // Reset in the middle of a pending request.
    lat_cfg = 3;
    wait_req(1'b0); wait_req(1'b1);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    h0 = hs_count;
    wait_hs(h0 + 1);
    chk("post_rst_pc", 64'(last_hs_pc), 64'd0);

    // Randomized traffic.
    lat_cfg = -1;
    h0 = hs_count;
    for (int i = 0; i < 4000; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 9) == 0);
      redirect_addr = ($urandom_range(0, 3) == 0) ? 20'hFFFFF : AW'($urandom);
      cyc(1);
    end
    redirect = 1'b0; instr_ready = 1'b1;
    cyc(20);
    chk("random_progress", 64'(hs_count > h0 + 100), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
